// File: rtl/obi_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between N_REQ masters, one transaction in flight.
// Define OBI_ARB_TIMEOUT_EN to add the response watchdog (ARB_ERR state and timeout_o).
module obi_arbiter #(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      obi_clk_i,
  input  logic                      soc_rst_ni,
  input  logic [N_REQ-1:0]          m_req_i,
  output logic [N_REQ-1:0]          m_gnt_o,
  input  logic [N_REQ*ADDR_W-1:0]   m_addr_i,
  input  logic [N_REQ-1:0]          m_wr_en_i,
  input  logic [N_REQ*DATA_W/8-1:0] m_byte_en_i,
  input  logic [N_REQ*DATA_W-1:0]   m_wdata_i,
  output logic [N_REQ-1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]         m_rdata_o,
  output logic                      s_req_o,
  input  logic                      s_gnt_i,
  output logic [ADDR_W-1:0]         s_addr_o,
  output logic                      s_wr_en_o,
  output logic [DATA_W/8-1:0]       s_byte_en_o,
  output logic [DATA_W-1:0]         s_wdata_o,
  input  logic                      s_rvalid_i,
  input  logic [DATA_W-1:0]         s_rdata_i,
  output logic                      busy_o,
`ifdef OBI_ARB_TIMEOUT_EN
  output logic                      timeout_o,
`endif
  output logic [$clog2(N_REQ)-1:0]  owner_o
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int BE_W  = DATA_W / 8;
  localparam int SUM_W = IDX_W + 1;

  generate
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("obi_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
`ifdef OBI_ARB_TIMEOUT_EN
    , ARB_ERR = 2'd3
`endif
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

`ifdef OBI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] rot_off;
  logic [SUM_W-1:0] pick_sum;
  logic [IDX_W-1:0] pick_idx;
  logic             any_req;

  // Rotate requests so bit 0 is the master at rr_ptr; the lowest set bit is the winner.
  always_comb begin
    req_rot = N_REQ'({m_req_i, m_req_i} >> rr_ptr_q);
    rot_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_off = IDX_W'(i);
    end
    any_req  = |m_req_i;
    pick_sum = SUM_W'(rr_ptr_q) + SUM_W'(rot_off);
    if (pick_sum >= SUM_W'(N_REQ)) pick_sum = pick_sum - SUM_W'(N_REQ);
    pick_idx = pick_sum[IDX_W-1:0];
  end

  logic              own_req;
  logic [ADDR_W-1:0] own_addr;
  logic              own_we;
  logic [BE_W-1:0]   own_be;
  logic [DATA_W-1:0] own_wdata;
  logic [N_REQ-1:0]  own_oh;
  logic [IDX_W-1:0]  rr_next;

  always_comb begin
    own_req   = 1'b0;
    own_addr  = '0;
    own_we    = 1'b0;
    own_be    = '0;
    own_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        own_req   = m_req_i[k];
        own_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
        own_we    = m_wr_en_i[k];
        own_be    = m_byte_en_i[k*BE_W +: BE_W];
        own_wdata = m_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign own_oh  = N_REQ'(1) << owner_q;
  assign rr_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    m_gnt_o     = '0;
    m_rvalid_o  = '0;
    m_rdata_o   = s_rdata_i;
    s_req_o     = 1'b0;
    s_addr_o    = '0;
    s_wr_en_o   = 1'b0;
    s_byte_en_o = '0;
    s_wdata_o   = '0;
`ifdef OBI_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d = pick_idx;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        s_req_o     = own_req;
        s_addr_o    = own_addr;
        s_wr_en_o   = own_we;
        s_byte_en_o = own_be;
        s_wdata_o   = own_wdata;
        m_gnt_o     = s_gnt_i ? own_oh : '0;
        if (own_req && s_gnt_i) begin
          state_d = ARB_RESP;
`ifdef OBI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!own_req) begin
          // Master withdrew before grant: re-arbitrate without moving the pointer.
          state_d = ARB_IDLE;
        end
      end
      ARB_RESP: begin
        m_rvalid_o = s_rvalid_i ? own_oh : '0;
        if (s_rvalid_i) begin
          rr_ptr_d = rr_next;
          state_d  = ARB_IDLE;
        end
`ifdef OBI_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ARB_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
`ifdef OBI_ARB_TIMEOUT_EN
      ARB_ERR: begin
        m_rvalid_o = own_oh;
        m_rdata_o  = DATA_W'(32'hDEAD_BEEF);
        timeout_d  = 1'b1;
        rr_ptr_d   = rr_next;
        state_d    = ARB_IDLE;
      end
`endif
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge obi_clk_i or negedge soc_rst_ni) begin
    if (!soc_rst_ni) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
`ifdef OBI_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
`ifdef OBI_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign busy_o  = (state_q != ARB_IDLE);
  assign owner_o = owner_q;
`ifdef OBI_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q | (state_q == ARB_ERR);
`endif

endmodule

// File: tb/tb_obi_arbiter.sv
// Scoreboard bench for obi_arbiter with two masters; the watchdog scenario runs when OBI_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_obi_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef OBI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_req = '0;
  logic [N-1:0]    m_gnt;
  logic [N*AW-1:0] m_addr = '0;
  logic [N-1:0]    m_wr_en = '0;
  logic [N*DW/8-1:0] m_be = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            s_req;
  logic            s_gnt = 1'b0;
  logic [AW-1:0]   s_addr;
  logic            s_wr_en;
  logic [DW/8-1:0] s_be;
  logic [DW-1:0]   s_wdata;
  logic            s_rvalid = 1'b0;
  logic [DW-1:0]   s_rdata = '0;
  logic            busy;
  logic [0:0]      owner;
`ifdef OBI_ARB_TIMEOUT_EN
  logic            timeout;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic          m;
    logic [DW-1:0] d;
  } resp_t;
  resp_t exp_q[$];
  resp_t mon_e;

  obi_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .obi_clk_i(clk), .soc_rst_ni(rst_n),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_wr_en_i(m_wr_en),
    .m_byte_en_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_wr_en_o(s_wr_en),
    .s_byte_en_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .busy_o(busy),
`ifdef OBI_ARB_TIMEOUT_EN
    .timeout_o(timeout),
`endif
    .owner_o(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  // Every response pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (m_rvalid !== 2'b00) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: m_rvalid_o=%b rdata=%h, required no response", m_rvalid, m_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_rvalid !== (mon_e.m ? 2'b10 : 2'b01) || m_rdata !== mon_e.d)
          $display("FAIL sb_resp: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                   m_rvalid, m_rdata, (mon_e.m ? 2'b10 : 2'b01), mon_e.d);
        else n_pass++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic set_m(input logic k, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    m_wr_en[k] = we;
    if (k) begin
      m_addr[2*AW-1:AW] = a; m_wdata[2*DW-1:DW] = d; m_be[7:4] = 4'hF;
    end else begin
      m_addr[AW-1:0] = a; m_wdata[DW-1:0] = d; m_be[3:0] = 4'hF;
    end
  endtask

  task automatic do_reset;
    tick; rst_n = 1'b0;
    tick; rst_n = 1'b1;
  endtask

  task automatic test_reset;
    smp;
    n_checks++;
    if ({m_gnt, m_rvalid, s_req, s_wr_en, s_be, busy, owner} !== 11'b0)
      $display("FAIL reset_ctrl: got %b, required all zero", {m_gnt, m_rvalid, s_req, s_wr_en, s_be, busy, owner});
    else n_pass++;
    n_checks++;
    if (s_addr !== 32'h0 || s_wdata !== 32'h0)
      $display("FAIL reset_data: addr=%h wdata=%h, required 0", s_addr, s_wdata);
    else n_pass++;
    n_checks++;
    if (m_rdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", m_rdata);
    else n_pass++;
    tick; rst_n = 1'b1;
  endtask

  task automatic test_single;
    set_m(1'b0, 32'h0000_1000, 1'b1, 32'hA5A5_5A5A);
    m_req = 2'b01;
    smp;
    n_checks++;
    if (busy !== 1'b0 || s_req !== 1'b0) $display("FAIL single_idle: busy=%b s_req=%b, required 0 0", busy, s_req);
    else n_pass++;
    tick; smp;
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_1000 || s_wdata !== 32'hA5A5_5A5A || s_wr_en !== 1'b1 || s_be !== 4'hF)
      $display("FAIL single_addr: req=%b addr=%h wdata=%h we=%b be=%h, required 1 00001000 a5a55a5a 1 f",
               s_req, s_addr, s_wdata, s_wr_en, s_be);
    else n_pass++;
    n_checks++;
    if (m_gnt !== 2'b00) $display("FAIL single_nognt: got %b, required 00", m_gnt);
    else n_pass++;
    tick; s_gnt = 1'b1; smp;
    n_checks++;
    if (m_gnt !== 2'b01) $display("FAIL single_gnt: got %b, required 01", m_gnt);
    else n_pass++;
    tick; s_gnt = 1'b0; m_req = 2'b00; smp;
    n_checks++;
    if (m_gnt !== 2'b00 || s_req !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_resp_wait: gnt=%b s_req=%b busy=%b, required 00 0 1", m_gnt, s_req, busy);
    else n_pass++;
    tick; s_rvalid = 1'b1; s_rdata = 32'h0; exp_q.push_back('{m: 1'b0, d: 32'h0}); smp;
    n_checks++;
    if (m_rvalid !== 2'b01) $display("FAIL single_rvalid: got %b, required 01", m_rvalid);
    else n_pass++;
    tick; s_rvalid = 1'b0; smp;
    n_checks++;
    if (busy !== 1'b0 || m_rvalid !== 2'b00) $display("FAIL single_done: busy=%b rvalid=%b, required 0 00", busy, m_rvalid);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    logic exp_o = 1'b0;
    logic [DW-1:0] rd;
    do_reset;
    set_m(1'b0, 32'h0000_0100, 1'b0, 32'h0);
    set_m(1'b1, 32'h0000_0200, 1'b0, 32'h0);
    m_req = 2'b11;
    for (int t = 0; t < 2; t++) begin
      rd = (t == 0) ? 32'h1111_1111 : 32'h2222_2222;
      tick; s_gnt = 1'b1; smp;
      n_checks++;
      if (owner !== exp_o || m_gnt !== (exp_o ? 2'b10 : 2'b01) || s_addr !== (exp_o ? 32'h200 : 32'h100))
        $display("FAIL simul_owner%0d: owner=%b gnt=%b addr=%h, required owner %b", t, owner, m_gnt, s_addr, exp_o);
      else n_pass++;
      tick; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = rd; exp_q.push_back('{m: exp_o, d: rd}); smp;
      tick; s_rvalid = 1'b0; smp;
      exp_o = ~exp_o;
    end
  endtask

  task automatic test_contention;
    logic exp_o = 1'b0;
    int bad = 0;
    logic [DW-1:0] rd;
    for (int t = 0; t < 8; t++) begin
      rd = 32'hC000_0000 + 32'(t);
      tick; s_gnt = 1'b1; smp;
      if (owner !== exp_o || m_gnt !== (exp_o ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL contention_owner%0d: owner=%b gnt=%b, required owner %b", t, owner, m_gnt, exp_o);
      end
      tick; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = rd; exp_q.push_back('{m: exp_o, d: rd});
      if (t == 7) m_req = 2'b00;
      smp;
      tick; s_rvalid = 1'b0; smp;
      exp_o = ~exp_o;
    end
    n_checks++;
    if (bad == 0) n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL contention_end: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_delayed_gnt;
    int bad = 0;
    tick; set_m(1'b0, 32'h0000_2000, 1'b1, 32'h0BAD_F00D); m_req = 2'b01; smp;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (k == 1) begin set_m(1'b1, 32'h0000_3000, 1'b0, 32'h0); m_req = 2'b11; end
      smp;
      if (s_req !== 1'b1 || s_addr !== 32'h0000_2000 || m_gnt !== 2'b00 || owner !== 1'b0) begin
        bad++;
        $display("FAIL delay_hold%0d: req=%b addr=%h gnt=%b owner=%b, required 1 00002000 00 0", k, s_req, s_addr, m_gnt, owner);
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
    tick; s_gnt = 1'b1; smp;
    n_checks++;
    if (m_gnt !== 2'b01) $display("FAIL delay_gnt: got %b, required 01", m_gnt);
    else n_pass++;
    tick; s_gnt = 1'b0; m_req = 2'b10; smp;
    tick; smp;
    n_checks++;
    if (m_gnt !== 2'b00 || s_req !== 1'b0 || busy !== 1'b1)
      $display("FAIL delay_m1_waits: gnt=%b s_req=%b busy=%b, required 00 0 1", m_gnt, s_req, busy);
    else n_pass++;
    tick; s_rvalid = 1'b1; s_rdata = 32'h0; exp_q.push_back('{m: 1'b0, d: 32'h0}); smp;
    tick; s_rvalid = 1'b0; smp;
    tick; s_gnt = 1'b1; smp;
    n_checks++;
    if (owner !== 1'b1 || s_addr !== 32'h0000_3000 || m_gnt !== 2'b10)
      $display("FAIL delay_m1_gnt: owner=%b addr=%h gnt=%b, required 1 00003000 10", owner, s_addr, m_gnt);
    else n_pass++;
    tick; s_gnt = 1'b0; m_req = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    exp_q.push_back('{m: 1'b1, d: 32'h1234_5678}); smp;
    tick; s_rvalid = 1'b0; s_rdata = 32'h0; smp;
  endtask

  task automatic test_reset_resp;
    tick; set_m(1'b1, 32'h0000_5000, 1'b0, 32'h0); m_req = 2'b10; smp;
    tick; s_gnt = 1'b1; smp;
    n_checks++;
    if (owner !== 1'b1) $display("FAIL rstresp_owner: got %b, required 1", owner);
    else n_pass++;
    tick; s_gnt = 1'b0; m_req = 2'b00; smp;
    tick; rst_n = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA; smp;
    n_checks++;
    if (busy !== 1'b0 || owner !== 1'b0 || m_rvalid !== 2'b00 || s_req !== 1'b0)
      $display("FAIL rstresp_clear: busy=%b owner=%b rvalid=%b s_req=%b, required all 0", busy, owner, m_rvalid, s_req);
    else n_pass++;
    tick; rst_n = 1'b1; smp;
    n_checks++;
    if (m_rvalid !== 2'b00 || busy !== 1'b0)
      $display("FAIL rstresp_late_rvalid: rvalid=%b busy=%b, required 00 0", m_rvalid, busy);
    else n_pass++;
    tick; s_rvalid = 1'b0; s_rdata = 32'h0; smp;
  endtask

  task automatic test_req_drop;
    do_reset;
    set_m(1'b0, 32'h0000_6000, 1'b0, 32'h0);
    set_m(1'b1, 32'h0000_7000, 1'b0, 32'h0);
    m_req = 2'b01; smp;
    tick; m_req = 2'b00; smp;
    n_checks++;
    if (s_req !== 1'b0 || m_gnt !== 2'b00) $display("FAIL drop_noreq: s_req=%b gnt=%b, required 0 00", s_req, m_gnt);
    else n_pass++;
    tick; m_req = 2'b11; smp;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL drop_idle: busy=%b, required 0", busy);
    else n_pass++;
    tick; s_gnt = 1'b1; smp;
    n_checks++;
    if (owner !== 1'b0 || m_gnt !== 2'b01) $display("FAIL drop_ptr_kept: owner=%b gnt=%b, required 0 01", owner, m_gnt);
    else n_pass++;
    tick; s_gnt = 1'b0; m_req = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h6666_0000;
    exp_q.push_back('{m: 1'b0, d: 32'h6666_0000}); smp;
    tick; s_rvalid = 1'b0; s_rdata = 32'h0; smp;
  endtask

`ifdef OBI_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int bad = 0;
    tick; set_m(1'b0, 32'h0000_8000, 1'b0, 32'h0); m_req = 2'b01; smp;
    tick; s_gnt = 1'b1; smp;
    for (int k = 0; k < 16; k++) begin
      tick;
      if (k == 0) begin s_gnt = 1'b0; m_req = 2'b00; end
      smp;
      if (m_rvalid !== 2'b00 || busy !== 1'b1 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL to_wait%0d: rvalid=%b busy=%b timeout=%b, required 00 1 0", k, m_rvalid, busy, timeout);
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
    tick; exp_q.push_back('{m: 1'b0, d: 32'hDEAD_BEEF}); smp;
    n_checks++;
    if (m_rvalid !== 2'b01 || m_rdata !== 32'hDEAD_BEEF || timeout !== 1'b1)
      $display("FAIL to_err: rvalid=%b rdata=%h timeout=%b, required 01 deadbeef 1", m_rvalid, m_rdata, timeout);
    else n_pass++;
    tick; s_rvalid = 1'b1; s_rdata = 32'h0000_0077; smp;
    n_checks++;
    if (m_rvalid !== 2'b00 || timeout !== 1'b1) $display("FAIL to_late: rvalid=%b timeout=%b, required 00 1", m_rvalid, timeout);
    else n_pass++;
    tick; s_rvalid = 1'b0; m_req = 2'b01; smp;
    tick; s_gnt = 1'b1; smp;
    n_checks++;
    if (m_gnt !== 2'b01) $display("FAIL to_next_gnt: got %b, required 01", m_gnt);
    else n_pass++;
    tick; s_gnt = 1'b0; m_req = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h3333_3333;
    exp_q.push_back('{m: 1'b0, d: 32'h3333_3333}); smp;
    tick; s_rvalid = 1'b0; smp;
    n_checks++;
    if (timeout !== 1'b1 || busy !== 1'b0) $display("FAIL to_sticky: timeout=%b busy=%b, required 1 0", timeout, busy);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_contention;
    test_delayed_gnt;
    test_reset_resp;
    test_req_drop;
`ifdef OBI_ARB_TIMEOUT_EN
    test_timeout;
`endif
    tick; smp;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
